// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters (p0 = EX stage, p1 = aux/debug) share one
// combinational ALU. A request is captured into operand registers, executed
// for one cycle, and the registered result is held on rsp_data until the
// granted port takes it. Each port has a 16-bit completed-operation counter.
//
// Build option:
//   ALU_ARB_RR_EN  defined   -> round-robin between the two ports
//                  undefined -> fixed priority, port 0 wins
//
// Operation codes: 0 add, 1 sub, 2 ori, 3 lui; every other code yields 0.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic [31:0] p0_req_a,
    input  logic [31:0] p0_req_b,
    input  logic [2:0]  p0_req_ctrl,
    output logic        p0_rsp_valid,
    input  logic        p0_rsp_ready,

    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic [31:0] p1_req_a,
    input  logic [31:0] p1_req_b,
    input  logic [2:0]  p1_req_ctrl,
    output logic        p1_rsp_valid,
    input  logic        p1_rsp_ready,

    output logic [31:0] rsp_data,
    output logic        busy,
    output logic [15:0] served_cnt0,
    output logic [15:0] served_cnt1
);

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_ORI = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
    } alu_op_t;

    state_t      state;
    alu_op_t     op;
    logic        gnt;
    logic        last;

    logic        gnt_c;
    logic        accept;
    logic        rsp_take;
    alu_op_t     req_c;
    logic [31:0] alu_y;

    // Pick the winning port from the request valids (meaningful in IDLE only)
    always_comb begin
        gnt_c = 1'b0;
`ifdef ALU_ARB_RR_EN
        if (p0_req_valid && p1_req_valid)
            gnt_c = ~last;
        else
            gnt_c = p1_req_valid;
`else
        gnt_c = ~p0_req_valid & p1_req_valid;
`endif
    end

`ifndef ALU_ARB_RR_EN
    // last is kept up to date in both builds but only steers round-robin
    logic unused_last;
    assign unused_last = last;
`endif

    // Ready never looks at rsp_ready, so no combinational path loops back
    assign p0_req_ready = (state == IDLE) && p0_req_valid && !gnt_c;
    assign p1_req_ready = (state == IDLE) && p1_req_valid &&  gnt_c;
    assign accept       = p0_req_ready | p1_req_ready;

    assign req_c = gnt_c ? alu_op_t'{p1_req_a, p1_req_b, p1_req_ctrl}
                         : alu_op_t'{p0_req_a, p0_req_b, p0_req_ctrl};

    // Non-granted port's rsp_ready has no effect
    assign rsp_take = gnt ? p1_rsp_ready : p0_rsp_ready;

    // Shared ALU, fed only from the captured operand registers
    always_comb begin
        alu_y = '0;
        case (op.ctrl)
            ALU_ADD: alu_y = op.a + op.b;
            ALU_SUB: alu_y = op.a - op.b;
            ALU_ORI: alu_y = op.a | {16'h0000, op.b[15:0]};
            ALU_LUI: alu_y = {op.b[15:0], 16'h0000};
            default: alu_y = '0;
        endcase
    end

    // Control FSM: capture, execute, hold result until the owner takes it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            gnt          <= 1'b0;
            last         <= 1'b1;
            op           <= '0;
            rsp_data     <= '0;
            served_cnt0  <= '0;
            served_cnt1  <= '0;
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op    <= req_c;
                        gnt   <= gnt_c;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data     <= alu_y;
                    p0_rsp_valid <= ~gnt;
                    p1_rsp_valid <=  gnt;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        if (gnt)
                            served_cnt1 <= served_cnt1 + 16'd1;
                        else
                            served_cnt0 <= served_cnt0 + 16'd1;
                        last         <= gnt;
                        p0_rsp_valid <= 1'b0;
                        p1_rsp_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: transaction-level reference for alu_arbiter. Each port has
// at most one pending request; the model picks the winner from the
// arbitration rule, computes the result with plain arithmetic, and tracks
// per-port served counts and the last-served port.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        p0_req_valid = 1'b0, p1_req_valid = 1'b0;
    logic [31:0] p0_req_a = '0, p0_req_b = '0, p1_req_a = '0, p1_req_b = '0;
    logic [2:0]  p0_req_ctrl = '0, p1_req_ctrl = '0;
    logic        p0_rsp_ready = 1'b0, p1_rsp_ready = 1'b0;
    wire         p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, busy;
    wire  [31:0] rsp_data;
    wire  [15:0] served_cnt0, served_cnt1;

    alu_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_req_a(p0_req_a), .p0_req_b(p0_req_b), .p0_req_ctrl(p0_req_ctrl),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_req_a(p1_req_a), .p1_req_b(p1_req_b), .p1_req_ctrl(p1_req_ctrl),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
        .rsp_data(rsp_data), .busy(busy),
        .served_cnt0(served_cnt0), .served_cnt1(served_cnt1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
    } req_t;

    req_t        pend [2];
    bit          has  [2];
    bit          m_last = 1'b1;
    logic [15:0] m_cnt [2] = '{16'd0, 16'd0};

    function automatic logic [31:0] alu_ref(input req_t r);
        logic [63:0] wide;
        case (r.ctrl)
            3'd0: wide = {32'd0, r.a} + {32'd0, r.b};
            3'd1: wide = {32'd0, r.a} - {32'd0, r.b};
            3'd2: wide = {32'd0, r.a | (r.b & 32'h0000_FFFF)};
            3'd3: wide = {32'd0, r.b} * 64'd65536;
            default: wide = 64'd0;
        endcase
        return wide[31:0];
    endfunction

    function automatic int pick();
        if (has[0] && has[1]) begin
`ifdef ALU_ARB_RR_EN
            return m_last ? 0 : 1;
`else
            return 0;
`endif
        end
        return has[0] ? 0 : 1;
    endfunction

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        pend[p].a = a; pend[p].b = b; pend[p].ctrl = c; has[p] = 1'b1;
    endtask

    task automatic new_req(input int p);
        set_req(p, $urandom, $urandom, 3'($urandom_range(0, 7)));
    endtask

    task automatic drive();
        p0_req_valid = has[0]; p0_req_a = pend[0].a; p0_req_b = pend[0].b; p0_req_ctrl = pend[0].ctrl;
        p1_req_valid = has[1]; p1_req_a = pend[1].a; p1_req_b = pend[1].b; p1_req_ctrl = pend[1].ctrl;
    endtask

    // One complete operation starting at a point just after a clock edge in
    // IDLE. delay = cycles the owner withholds rsp_ready; refill = re-post
    // requests on every idle port right after acceptance.
    task automatic run_txn(input int delay, input bit refill);
        int g;
        logic [31:0] res;
        drive();
        #1;
        g = pick();
        chk("req_ready0_idle", p0_req_ready, has[0] && g == 0);
        chk("req_ready1_idle", p1_req_ready, has[1] && g == 1);
        chk("busy_idle", busy, 0);
        res = alu_ref(pend[g]);
        @(posedge clk); #1;
        has[g] = 1'b0;
        if (refill) begin
            if (!has[0]) new_req(0);
            if (!has[1]) new_req(1);
        end
        if (g == 0) begin p0_rsp_ready = 1'b0; p1_rsp_ready = 1'($urandom_range(0, 1)); end
        else        begin p1_rsp_ready = 1'b0; p0_rsp_ready = 1'($urandom_range(0, 1)); end
        drive();
        #1;
        chk("busy_exec", busy, 1);
        chk("rsp_valid_exec", {p1_rsp_valid, p0_rsp_valid}, 0);
        chk("req_ready_exec", {p1_req_ready, p0_req_ready}, 0);
        @(posedge clk); #1;
        for (int i = 0; i <= delay; i++) begin
            chk("rsp_valid_resp", {p1_rsp_valid, p0_rsp_valid}, (g == 1) ? 2'b10 : 2'b01);
            chk("rsp_data", rsp_data, res);
            chk("req_ready_resp", {p1_req_ready, p0_req_ready}, 0);
            if (i == delay) begin
                if (g == 0) p0_rsp_ready = 1'b1; else p1_rsp_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        m_cnt[g] = m_cnt[g] + 16'd1;
        m_last   = (g == 1);
        chk("rsp_valid_done", {p1_rsp_valid, p0_rsp_valid}, 0);
        chk("busy_done", busy, 0);
        chk("served_cnt0", served_cnt0, m_cnt[0]);
        chk("served_cnt1", served_cnt1, m_cnt[1]);
        p0_rsp_ready = 1'b0;
        p1_rsp_ready = 1'b0;
    endtask

    task automatic drain();
        while (has[0] || has[1]) run_txn(0, 1'b0);
    endtask

    initial begin
        logic [15:0] c0, c1;
        has[0] = 1'b0; has[1] = 1'b0;
        pend[0] = '{32'd0, 32'd0, 3'd0};
        pend[1] = '{32'd0, 32'd0, 3'd0};
        drive();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", {p1_rsp_valid, p0_rsp_valid}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_cnt0", served_cnt0, 0);
        chk("rst_cnt1", served_cnt1, 0);
        chk("rst_req_ready", {p1_req_ready, p0_req_ready}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single add on port 0
        set_req(0, 32'h0000_0005, 32'h0000_0003, 3'd0);
        run_txn(0, 1'b0);
        chk("add_cnt0_is_1", served_cnt0, 16'd1);

        // Individual operations with wrap-around and unknown code
        set_req(1, 32'h0000_0000, 32'h0000_0001, 3'd1); run_txn(0, 1'b0);
        set_req(0, 32'h1234_0000, 32'hFFFF_00FF, 3'd2); run_txn(1, 1'b0);
        set_req(1, 32'hDEAD_BEEF, 32'h0000_ABCD, 3'd3); run_txn(0, 1'b0);
        set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7); run_txn(2, 1'b0);

        // Contention: both ports valid for four operations
        c0 = served_cnt0; c1 = served_cnt1;
        new_req(0); new_req(1);
        repeat (4) run_txn(0, 1'b1);
`ifdef ALU_ARB_RR_EN
        chk("contend_cnt0", served_cnt0 - c0, 2);
        chk("contend_cnt1", served_cnt1 - c1, 2);
`else
        chk("contend_cnt0", served_cnt0 - c0, 4);
        chk("contend_cnt1", served_cnt1 - c1, 0);
`endif
        drain();

        // Backpressure on p1 while p0 waits; p0 goes next
        new_req(1);
        run_txn(10, 1'b1);
        chk("bp_p0_pending", has[0], 1);
        run_txn(0, 1'b0);
        drain();

        // Reset during EXEC drops the operation
        new_req(0); drive();
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {p1_rsp_valid, p0_rsp_valid}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt0", served_cnt0, 0);
        chk("mid_rst_cnt1", served_cnt1, 0);
        has[0] = 1'b0; has[1] = 1'b0; drive();
        m_cnt[0] = 16'd0; m_cnt[1] = 16'd0; m_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_rsp", {p1_rsp_valid, busy, p0_rsp_valid}, 0);
        end

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            if (!has[0] && $urandom_range(0, 1) == 1) new_req(0);
            if (!has[1] && $urandom_range(0, 1) == 1) new_req(1);
            if (!has[0] && !has[1]) new_req($urandom_range(0, 1));
            run_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        drain();

        // served_cnt1 wraps from 0xFFFF to 0
        force dut.served_cnt1 = 16'hFFFF;
        @(posedge clk); #1;
        release dut.served_cnt1;
        m_cnt[1] = 16'hFFFF;
        #1;
        chk("wrap_preload", served_cnt1, 16'hFFFF);
        new_req(1);
        run_txn(0, 1'b0);
        chk("wrap_cnt1_zero", served_cnt1, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
